// File: rtl/fifo_if.sv
// Handshake and status bundle between a synchronous FIFO and its user.
// The user side drives requests and write data. The FIFO side returns read data and status.
interface fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, wdata, r_en,
    input  rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  w_en, wdata, r_en,
    output rdata, rvalid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_non2n.sv
// Single-clock FIFO of arbitrary depth with registered read data, fill-level flags
// and sticky overflow/underflow indicators.
module fifo_sync_non2n #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int AF_LEVEL   = 8,
  parameter int AE_LEVEL   = 2
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full_c  = (count_q == CNT_FULL);
  assign empty_c = (count_q == '0);
  assign wr_acc  = bus.w_en & ~full_c;
  assign rd_acc  = bus.r_en & ~empty_c;

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (wr_acc) begin
        wptr <= ptr_next(wptr);
      end
      if (rd_acc) begin
        rptr    <= ptr_next(rptr);
        rdata_q <= mem[rptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.w_en && full_c) begin
        overflow_q <= 1'b1;
      end
      if (bus.r_en && empty_c) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
